// File: rtl/ir_nec_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ir_nec_pkg
//  Purpose  : NEC IR transmit timing constants, state encoding and helpers.
//  Revision : 1.0
// ============================================================================
package ir_nec_pkg;

    localparam int LEAD_MARK_U  = 16;
    localparam int LEAD_SPACE_U = 8;
    localparam int REP_SPACE_U  = 4;
    localparam int BIT_MARK_U   = 1;
    localparam int ZERO_SPACE_U = 1;
    localparam int ONE_SPACE_U  = 3;
    localparam int STOP_U       = 1;
    localparam int NBITS        = 32;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE       = 3'd0;
    localparam state_t ST_LEAD_MARK  = 3'd1;
    localparam state_t ST_LEAD_SPACE = 3'd2;
    localparam state_t ST_BIT_MARK   = 3'd3;
    localparam state_t ST_BIT_SPACE  = 3'd4;
    localparam state_t ST_STOP_MARK  = 3'd5;
    localparam state_t ST_GAP        = 3'd6;

    // Length in units of the segment a state represents (GAP/IDLE are open-ended).
    function automatic logic [4:0] seg_units(input state_t st, input logic rep, input logic bit0);
        logic [4:0] n;
        n = 5'd1;
        case (st)
            ST_LEAD_MARK:  n = 5'(LEAD_MARK_U);
            ST_LEAD_SPACE: n = rep ? 5'(REP_SPACE_U) : 5'(LEAD_SPACE_U);
            ST_BIT_MARK:   n = 5'(BIT_MARK_U);
            ST_BIT_SPACE:  n = bit0 ? 5'(ONE_SPACE_U) : 5'(ZERO_SPACE_U);
            ST_STOP_MARK:  n = 5'(STOP_U);
            default:       n = 5'd1;
        endcase
        return n;
    endfunction

    function automatic logic is_mark(input state_t st);
        return (st == ST_LEAD_MARK) || (st == ST_BIT_MARK) || (st == ST_STOP_MARK);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ir_carrier_gen.sv
`default_nettype none
// ============================================================================
//  Module   : ir_carrier_gen
//  Purpose  : Restartable carrier square wave, held low while disabled.
//  Revision : 1.0
// ============================================================================
module ir_carrier_gen #(
    parameter int CAR_HALF = 316
) (
    input  logic clk_in,
    input  logic rst,
    input  logic restart,
    input  logic enable,
    output logic carrier
);

    localparam int CW = (CAR_HALF > 1) ? $clog2(CAR_HALF) : 1;
    localparam logic [CW-1:0] C_HALF_LAST = CW'(CAR_HALF - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          car_q, car_d;

    // Restart lands the first mark cycle on a high half-period with a fresh count.
    always_comb begin
        cnt_d = cnt_q;
        car_d = car_q;
        if (restart) begin
            cnt_d = '0;
            car_d = 1'b1;
        end else if (enable) begin
            if (cnt_q == C_HALF_LAST) begin
                cnt_d = '0;
                car_d = ~car_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = '0;
            car_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt_q <= '0;
            car_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            car_q <= car_d;
        end
    end

    assign carrier = car_q;

endmodule
`default_nettype wire

// File: rtl/ir_tx_nec.sv
`default_nettype none
// ============================================================================
//  Module   : ir_tx_nec
//  Purpose  : NEC infrared transmitter (data and repeat frames, carrier drive).
//  Revision : 1.0
// ============================================================================
module ir_tx_nec
    import ir_nec_pkg::*;
#(
    parameter int UNIT_CLKS   = 13500,
    parameter int CAR_HALF    = 316,
    parameter int FRAME_UNITS = 192,
    parameter bit IR_INV      = 1'b0
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       tx_repeat,
    input  logic [7:0] tx_addr,
    input  logic [7:0] tx_cmd,
    output logic       ir_env,
    output logic       ir_out,
    output logic       busy,
    output logic       done
);

    localparam int PW = (UNIT_CLKS > 1) ? $clog2(UNIT_CLKS) : 1;
    localparam int FW = $clog2(FRAME_UNITS + 1);
    localparam logic [PW-1:0] C_PRESC_LAST = PW'(UNIT_CLKS - 1);
    localparam logic [FW-1:0] C_FRAME_LAST = FW'(FRAME_UNITS - 1);
    localparam logic [FW-1:0] C_FRAME_FULL = FW'(FRAME_UNITS);
    localparam logic [5:0]    C_NBITS      = 6'(NBITS);

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [4:0]    seg_q,   seg_d;
    logic [FW-1:0] frame_q, frame_d;
    logic [31:0]   sr_q,    sr_d;
    logic          rep_q,   rep_d;
    logic [5:0]    bits_q,  bits_d;

    logic       w_busy;
    logic       w_unit_tick;
    logic [4:0] w_seg_len;
    logic       w_seg_end;
    logic       w_gap_end;
    logic [5:0] w_bits_inc;
    logic       w_mark_q;
    logic       w_mark_d;
    logic       w_carrier;

    assign w_busy      = (state_q != ST_IDLE);
    assign w_unit_tick = w_busy && (presc_q == C_PRESC_LAST);
    assign w_seg_len   = seg_units(state_q, rep_q, sr_q[0]);
    assign w_seg_end   = w_unit_tick && (seg_q == (w_seg_len - 5'd1));
    assign w_bits_inc  = bits_q + 6'd1;
    // GAP ends on the tick that brings the frame count to FRAME_UNITS.
    assign w_gap_end   = (state_q == ST_GAP) &&
                         ((w_unit_tick && (frame_q == C_FRAME_LAST)) || (frame_q == C_FRAME_FULL));

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        seg_d   = seg_q;
        frame_d = frame_q;
        sr_d    = sr_q;
        rep_d   = rep_q;
        bits_d  = bits_q;

        if (w_busy) begin
            presc_d = w_unit_tick ? '0 : (presc_q + 1'b1);
            if (w_unit_tick && (frame_q != C_FRAME_FULL)) begin
                frame_d = frame_q + 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (tx_valid) begin
                    sr_d    = {~tx_cmd, tx_cmd, ~tx_addr, tx_addr};
                    rep_d   = tx_repeat;
                    presc_d = '0;
                    seg_d   = '0;
                    frame_d = '0;
                    bits_d  = '0;
                    state_d = ST_LEAD_MARK;
                end
            end
            ST_GAP: begin
                if (w_gap_end) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                if (w_unit_tick) begin
                    seg_d = w_seg_end ? 5'd0 : (seg_q + 5'd1);
                end
                if (w_seg_end) begin
                    case (state_q)
                        ST_LEAD_MARK:  state_d = ST_LEAD_SPACE;
                        ST_LEAD_SPACE: state_d = rep_q ? ST_STOP_MARK : ST_BIT_MARK;
                        ST_BIT_MARK:   state_d = ST_BIT_SPACE;
                        ST_BIT_SPACE: begin
                            sr_d    = {1'b0, sr_q[31:1]};
                            bits_d  = w_bits_inc;
                            state_d = (w_bits_inc < C_NBITS) ? ST_BIT_MARK : ST_STOP_MARK;
                        end
                        ST_STOP_MARK:  state_d = ST_GAP;
                        default:       state_d = ST_IDLE;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            seg_q   <= '0;
            frame_q <= '0;
            sr_q    <= '0;
            rep_q   <= 1'b0;
            bits_q  <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            seg_q   <= seg_d;
            frame_q <= frame_d;
            sr_q    <= sr_d;
            rep_q   <= rep_d;
            bits_q  <= bits_d;
        end
    end

    // Marks never follow marks directly, so every mark entry restarts the carrier.
    assign w_mark_q = is_mark(state_q);
    assign w_mark_d = is_mark(state_d);

    ir_carrier_gen #(
        .CAR_HALF (CAR_HALF)
    ) u_carrier (
        .clk_in  (clk_in),
        .rst     (rst),
        .restart (w_mark_d & ~w_mark_q),
        .enable  (w_mark_d),
        .carrier (w_carrier)
    );

    assign tx_ready = ~w_busy;
    assign busy     = w_busy;
    assign done     = w_gap_end;
    assign ir_env   = w_mark_q;
    assign ir_out   = (w_mark_q & w_carrier) ^ IR_INV;

endmodule
`default_nettype wire

// File: tb/tb_ir_tx_nec.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ir_tx_nec
//  Purpose  : Self-checking bench for ir_tx_nec against a segment-level model.
//  Revision : 1.0
// ============================================================================
module tb_ir_tx_nec;

    localparam int U  = 8;
    localparam int CH = 2;
    localparam int FU = 192;
    localparam int FL = FU * U;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_valid;
    logic       tx_repeat;
    logic [7:0] tx_addr;
    logic [7:0] tx_cmd;
    logic       tx_ready, ir_env, ir_out, busy, done;
    logic       tx_ready_i, ir_env_i, ir_out_inv, busy_i, done_i;

    int n_checks = 0;
    int n_fail   = 0;

    logic env_tr  [0:FL+1];
    logic out_tr  [0:FL+1];
    logic inv_tr  [0:FL+1];
    logic done_tr [0:FL+1];
    logic rdy_tr  [0:FL+1];
    logic busy_tr [0:FL+1];
    bit   exp_env [0:FL+1];
    bit   exp_out [0:FL+1];
    bit   exp_done[0:FL+1];
    int   rl_len[$];
    logic rl_lvl[$];

    always #5 clk = ~clk;

    ir_tx_nec #(.UNIT_CLKS(U), .CAR_HALF(CH), .FRAME_UNITS(FU), .IR_INV(1'b0)) dut (
        .clk_in(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_repeat(tx_repeat), .tx_addr(tx_addr), .tx_cmd(tx_cmd),
        .ir_env(ir_env), .ir_out(ir_out), .busy(busy), .done(done)
    );

    ir_tx_nec #(.UNIT_CLKS(U), .CAR_HALF(CH), .FRAME_UNITS(FU), .IR_INV(1'b1)) dut_inv (
        .clk_in(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(tx_ready_i),
        .tx_repeat(tx_repeat), .tx_addr(tx_addr), .tx_cmd(tx_cmd),
        .ir_env(ir_env_i), .ir_out(ir_out_inv), .busy(busy_i), .done(done_i)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected per-cycle waveform (cycle 1 = first cycle after the accept edge).
    task automatic build_model(input logic [7:0] a, input logic [7:0] c, input bit rep);
        int          sn[$];
        bit          sl[$];
        logic [31:0] w;
        int          t;
        w = {~c, c, ~a, a};
        sn.push_back(16); sl.push_back(1'b1);
        sn.push_back(rep ? 4 : 8); sl.push_back(1'b0);
        if (!rep) begin
            for (int i = 0; i < 32; i++) begin
                sn.push_back(1); sl.push_back(1'b1);
                sn.push_back(w[i] ? 3 : 1); sl.push_back(1'b0);
            end
        end
        sn.push_back(1); sl.push_back(1'b1);
        t = 1;
        for (int s = 0; s < sn.size(); s++) begin
            for (int j = 0; j < sn[s] * U; j++) begin
                exp_env[t] = sl[s];
                exp_out[t] = sl[s] && (((j / CH) % 2) == 0);
                t++;
            end
        end
        while (t <= FL + 1) begin
            exp_env[t] = 1'b0;
            exp_out[t] = 1'b0;
            t++;
        end
        for (int k = 0; k <= FL + 1; k++) exp_done[k] = (k == FL);
    endtask

    // Accept at the next edge, then record cycles 1..FL+1 at each falling edge.
    task automatic run_frame(input logic [7:0] a, input logic [7:0] c, input bit rep, input bit hold);
        tx_addr = a; tx_cmd = c; tx_repeat = rep; tx_valid = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= FL + 1; k++) begin
            @(negedge clk);
            env_tr[k] = ir_env;   out_tr[k] = ir_out;  inv_tr[k] = ir_out_inv;
            done_tr[k] = done;    rdy_tr[k] = tx_ready; busy_tr[k] = busy;
            if (k <= FL) begin
                if (hold) begin
                    tx_addr = 8'($urandom); tx_cmd = 8'($urandom); tx_repeat = 1'($urandom);
                end else begin
                    tx_valid = 1'b0;
                end
            end
        end
    endtask

    task automatic trace_errs(output int n, output int first);
        n = 0; first = -1;
        for (int k = 1; k <= FL + 1; k++) begin
            if (env_tr[k] !== exp_env[k] || out_tr[k] !== exp_out[k] ||
                inv_tr[k] !== ~exp_out[k] || done_tr[k] !== exp_done[k] ||
                rdy_tr[k] !== (k == FL + 1) || busy_tr[k] !== (k != FL + 1)) begin
                if (first < 0) first = k;
                n++;
            end
        end
    endtask

    task automatic get_runs;
        rl_len.delete(); rl_lvl.delete();
        for (int k = 1; k <= FL; k++) begin
            if (rl_len.size() == 0 || rl_lvl[rl_lvl.size()-1] !== env_tr[k]) begin
                rl_len.push_back(1); rl_lvl.push_back(env_tr[k]);
            end else begin
                rl_len[rl_len.size()-1] = rl_len[rl_len.size()-1] + 1;
            end
        end
    endtask

    function automatic int rlen(input int i);
        return (i < rl_len.size()) ? rl_len[i] : -1;
    endfunction

    // Bits recovered from space widths; bad counts marks/spaces of illegal width.
    task automatic decode_word(output logic [31:0] w, output int bad);
        bad = 0; w = '0;
        for (int i = 0; i < 32; i++) begin
            if (rlen(2 + 2*i) != U) bad++;
            if (rlen(3 + 2*i) != U && rlen(3 + 2*i) != 3*U) bad++;
            w[i] = (rlen(3 + 2*i) == 3*U);
        end
    endtask

    function automatic int last_high;
        int r = -1;
        for (int k = 1; k <= FL; k++) if (env_tr[k] === 1'b1) r = k;
        return r;
    endfunction

    task automatic test_reset;
        rst = 1'b1; tx_valid = 1'b0; tx_repeat = 1'b0; tx_addr = '0; tx_cmd = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", tx_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (ir_env !== 1'b0) begin n_fail++; $display("FAIL reset_env: got %b want 0", ir_env); end
        n_checks++; if (ir_out !== 1'b0) begin n_fail++; $display("FAIL reset_out: got %b want 0", ir_out); end
        n_checks++; if (ir_out_inv !== 1'b1) begin n_fail++; $display("FAIL reset_out_inv: got %b want 1", ir_out_inv); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (tx_ready !== 1'b1 || ir_env !== 1'b0) begin
            n_fail++; $display("FAIL idle_after_reset: ready=%b env=%b want 1/0", tx_ready, ir_env);
        end
    endtask

    task automatic test_basic;
        int n, first, bad;
        logic [31:0] w;
        build_model(8'h00, 8'h45, 1'b0);
        run_frame(8'h00, 8'h45, 1'b0, 1'b0);
        trace_errs(n, first);
        n_checks++; if (n !== 0) begin n_fail++; $display("FAIL basic_trace: %0d bad cycles (first %0d), want 0", n, first); end
        get_runs();
        n_checks++; if (rlen(0) !== 128 || rl_lvl[0] !== 1'b1) begin
            n_fail++; $display("FAIL basic_lead_mark: got %0d want 128", rlen(0));
        end
        n_checks++; if (rlen(1) !== 64) begin n_fail++; $display("FAIL basic_lead_space: got %0d want 64", rlen(1)); end
        decode_word(w, bad);
        n_checks++; if (w !== 32'hBA45_FF00) begin n_fail++; $display("FAIL basic_word: got %h want ba45ff00", w); end
        n_checks++; if (bad !== 0 || rlen(66) !== U) begin
            n_fail++; $display("FAIL basic_widths: bad=%0d stop=%0d want 0/%0d", bad, rlen(66), U);
        end
        n_checks++; if (done_tr[FL] !== 1'b1) begin n_fail++; $display("FAIL basic_done: got %b at 1536 want 1", done_tr[FL]); end
    endtask

    task automatic test_stop_edge;
        int n, first, bad;
        logic [31:0] w;
        logic [7:0] v;
        for (int p = 0; p < 2; p++) begin
            v = (p == 0) ? 8'hFF : 8'h00;
            build_model(v, v, 1'b0);
            run_frame(v, v, 1'b0, 1'b0);
            trace_errs(n, first);
            n_checks++; if (n !== 0) begin n_fail++; $display("FAIL stop_trace_%0d: %0d bad cycles (first %0d), want 0", p, n, first); end
            n_checks++; if (last_high() !== 121 * U) begin
                n_fail++; $display("FAIL stop_fall_%0d: got %0d want %0d", p, last_high(), 121 * U);
            end
            get_runs();
            decode_word(w, bad);
            n_checks++; if (bad !== 0 || w !== {~v, v, ~v, v}) begin
                n_fail++; $display("FAIL stop_marks_%0d: bad=%0d word=%h want 0/%h", p, bad, w, {~v, v, ~v, v});
            end
        end
    endtask

    task automatic test_repeat;
        int n, first;
        logic [7:0] a, c;
        a = 8'($urandom); c = 8'($urandom);
        build_model(a, c, 1'b1);
        run_frame(a, c, 1'b1, 1'b0);
        trace_errs(n, first);
        n_checks++; if (n !== 0) begin n_fail++; $display("FAIL repeat_trace: %0d bad cycles (first %0d), want 0", n, first); end
        get_runs();
        n_checks++; if (rl_len.size() !== 4 || rlen(0) !== 128 || rlen(1) !== 32 || rlen(2) !== 8) begin
            n_fail++; $display("FAIL repeat_shape: runs=%0d %0d/%0d/%0d want 4 128/32/8",
                               rl_len.size(), rlen(0), rlen(1), rlen(2));
        end
        n_checks++; if (rdy_tr[FL] !== 1'b0 || rdy_tr[FL+1] !== 1'b1) begin
            n_fail++; $display("FAIL repeat_ready: got %b%b want 01", rdy_tr[FL], rdy_tr[FL+1]);
        end
    endtask

    task automatic test_carrier;
        int n, first, tog, space_hi;
        logic [7:0] a, c;
        a = 8'($urandom); c = 8'($urandom);
        build_model(a, c, 1'b0);
        run_frame(a, c, 1'b0, 1'b0);
        trace_errs(n, first);
        n_checks++; if (n !== 0) begin n_fail++; $display("FAIL carrier_trace: %0d bad cycles (first %0d), want 0", n, first); end
        tog = 0; space_hi = 0;
        for (int k = 2; k <= 128; k++) if (out_tr[k] !== out_tr[k-1]) tog++;
        for (int k = 1; k <= FL; k++) if (env_tr[k] === 1'b0 && out_tr[k] !== 1'b0) space_hi++;
        n_checks++; if (out_tr[1] !== 1'b1 || tog !== 63) begin
            n_fail++; $display("FAIL carrier_leader: first=%b toggles=%0d want 1/63", out_tr[1], tog);
        end
        n_checks++; if (space_hi !== 0) begin n_fail++; $display("FAIL carrier_space: %0d high cycles want 0", space_hi); end
        n_checks++; if (inv_tr[FL+1] !== 1'b1) begin n_fail++; $display("FAIL carrier_inv_idle: got %b want 1", inv_tr[FL+1]); end
    endtask

    task automatic test_random;
        int n, first, bad;
        logic [31:0] w;
        logic [7:0] a, c;
        bit rep;
        for (int i = 0; i < 3; i++) begin
            a = 8'($urandom); c = 8'($urandom); rep = ($urandom_range(0, 3) == 0);
            build_model(a, c, rep);
            run_frame(a, c, rep, 1'b0);
            trace_errs(n, first);
            n_checks++; if (n !== 0) begin n_fail++; $display("FAIL random_trace_%0d: %0d bad cycles (first %0d), want 0", i, n, first); end
            if (!rep) begin
                get_runs();
                decode_word(w, bad);
                n_checks++; if (w !== {~c, c, ~a, a} || bad !== 0) begin
                    n_fail++; $display("FAIL random_word_%0d: got %h bad=%0d want %h", i, w, bad, {~c, c, ~a, a});
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        int n, first;
        logic [7:0] a, c;
        a = 8'($urandom); c = 8'($urandom);
        build_model(a, c, 1'b0);
        run_frame(a, c, 1'b0, 1'b1);
        trace_errs(n, first);
        n_checks++; if (n !== 0) begin n_fail++; $display("FAIL b2b_first: %0d bad cycles (first %0d), want 0", n, first); end
        a = 8'($urandom); c = 8'($urandom);
        build_model(a, c, 1'b0);
        run_frame(a, c, 1'b0, 1'b1);
        tx_valid = 1'b0;
        trace_errs(n, first);
        n_checks++; if (n !== 0) begin n_fail++; $display("FAIL b2b_second: %0d bad cycles (first %0d), want 0", n, first); end
        @(negedge clk);
        n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_idle: ready=%b want 1", tx_ready); end
    endtask

    task automatic test_reset_mid;
        int n, first, dones;
        logic was_busy;
        dones = 0; was_busy = 1'b0;
        tx_addr = 8'($urandom); tx_cmd = 8'($urandom); tx_repeat = 1'b0; tx_valid = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 500; k++) begin
            @(negedge clk);
            tx_valid = 1'b0;
            if (done === 1'b1) dones++;
            if (k == 500) begin was_busy = busy; rst = 1'b1; end
        end
        @(negedge clk);
        if (done === 1'b1) dones++;
        n_checks++; if (was_busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy: got %b want 1", was_busy); end
        n_checks++; if (ir_env !== 1'b0 || ir_out !== 1'b0 || ir_out_inv !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_outputs: env=%b out=%b inv=%b want 0/0/1", ir_env, ir_out, ir_out_inv);
        end
        n_checks++; if (tx_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_ready: ready=%b busy=%b want 1/0", tx_ready, busy);
        end
        n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL rstmid_done: %0d pulses want 0", dones); end
        rst = 1'b0;
        @(negedge clk);
        build_model(8'h5A, 8'hC3, 1'b0);
        run_frame(8'h5A, 8'hC3, 1'b0, 1'b0);
        trace_errs(n, first);
        n_checks++; if (n !== 0) begin n_fail++; $display("FAIL rstmid_next: %0d bad cycles (first %0d), want 0", n, first); end
        get_runs();
        n_checks++; if (rlen(0) !== 128) begin n_fail++; $display("FAIL rstmid_leader: got %0d want 128", rlen(0)); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stop_edge();
        test_repeat();
        test_carrier();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
